v_hier_sched: RTL and testbench

Round-robin scheduler that shares one `v_hier_sub` datapath (4-bit `avec` in, 4-bit `qvec` out) among NREQ requesters. It arbitrates pending requests and drives the winner's operand onto `avec`. It then waits a fixed datapath latency, captures `qvec`, and returns the result to the winner with a one-cycle `done` pulse. It sits directly above `v_hier_sub` in the hierarchy; requesters never touch the datapath ports.

---
 rtl/v_hier_sched.sv | 105 ++++++++++
 tb/tb_v_hier_sched.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/v_hier_sched.sv
// v_hier_sched: round-robin scheduler sharing one v_hier_sub datapath among
// NREQ requesters. The winner's operand is latched onto avec, held for LAT
// cycles, then qvec is captured into rdata and returned with a done pulse.
module v_hier_sched #(
  parameter int NREQ = 4,
  parameter int W    = 4,
  parameter int LAT  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] opnd,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [W-1:0]      rdata,
  output logic              busy,
  output logic [W-1:0]      avec,
  input  logic [W-1:0]      qvec
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(LAT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [PW-1:0] ptr;
  logic [CW-1:0] cnt;
  logic [PW-1:0] win;
  logic [PW-1:0] idx;
  logic          found;
  logic [W-1:0]  opsel;

  // Round-robin search: first active request after the last winner, wrapping.
  always_comb begin
    win   = ptr;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign opsel = opnd[int'(win)*W +: W];

  // Grant, hold for LAT cycles, capture the result and pulse done for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      gnt   <= '0;
      done  <= '0;
      avec  <= '0;
      rdata <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      ptr   <= PW'(NREQ - 1);
    end else begin
      case (state)
        S_IDLE: begin
          done <= '0;
          if (found) begin
            gnt   <= NREQ'(1) << win;
            avec  <= opsel;
            ptr   <= win;
            cnt   <= CW'(LAT);
            busy  <= 1'b1;
            state <= S_WAIT;
          end else begin
            avec <= '0;
            busy <= 1'b0;
          end
        end
        S_WAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            rdata <= qvec;
            done  <= gnt;
            gnt   <= '0;
            avec  <= '0;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= '0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          gnt   <= '0;
          done  <= '0;
          avec  <= '0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_v_hier_sched.sv
// Testbench for v_hier_sched: directed scenarios plus randomized operations
// checked against an operation-level round-robin reference model.
module tb_v_hier_sched;

  localparam int NREQ = 4;
  localparam int W    = 4;
  localparam int LAT  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] opnd;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [3:0]  rdata;
  logic        busy;
  logic [3:0]  avec;
  logic [3:0]  qvec;

  int n_checks = 0;
  int n_fail   = 0;
  int model_ptr;

  v_hier_sched #(.NREQ(NREQ), .W(W), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .opnd(opnd), .gnt(gnt), .done(done),
    .rdata(rdata), .busy(busy), .avec(avec), .qvec(qvec)
  );

  // Datapath stand-in: result is the bitwise inverse of the operand.
  assign qvec = ~avec;

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req = '0;
    tick;
    rst = 1'b0;
    model_ptr = NREQ - 1;
  endtask

  function automatic int rr_pick(input int last, input logic [3:0] r);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic test_reset;
    rst  = 1'b1;
    req  = 4'b1111;
    opnd = 16'h1234;
    for (int c = 0; c < 2; c++) begin
      tick;
      n_checks++;
      if (gnt !== 4'b0 || done !== 4'b0 || avec !== 4'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL reset_outputs: gnt=%b done=%b avec=%h busy=%b expected all zero", gnt, done, avec, busy);
      end
    end
    rst = 1'b0;
    tick;
    n_checks++;
    if (gnt !== 4'b0001) begin
      n_fail++;
      $display("[TB] FAIL reset_first_grant: gnt=%b expected 0001", gnt);
    end
    req = '0;
    for (int c = 0; c < LAT + 1; c++) tick;
  endtask

  task automatic test_single;
    do_reset;
    req  = 4'b0100;
    opnd = 16'h0A00;
    for (int c = 1; c <= LAT; c++) begin
      tick;
      n_checks++;
      if (gnt !== 4'b0100 || avec !== 4'hA || busy !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL single_wait c%0d: gnt=%b avec=%h busy=%b expected 0100 a 1", c, gnt, avec, busy);
      end
    end
    tick;
    n_checks++;
    if (done !== 4'b0100 || rdata !== 4'h5 || gnt !== 4'b0) begin
      n_fail++;
      $display("[TB] FAIL single_done: done=%b rdata=%h gnt=%b expected 0100 5 0000", done, rdata, gnt);
    end
    req = '0;
    tick;
    n_checks++;
    if (busy !== 1'b0 || done !== 4'b0) begin
      n_fail++;
      $display("[TB] FAIL single_idle: busy=%b done=%b expected 0 0000", busy, done);
    end
  endtask

  task automatic test_round_robin;
    int order[5] = '{0, 1, 2, 3, 0};
    logic [3:0] ops[4];
    do_reset;
    req  = 4'b1111;
    opnd = 16'h9C5A;
    ops  = '{4'hA, 4'h5, 4'hC, 4'h9};
    for (int n = 0; n < 5; n++) begin
      for (int c = 1; c <= LAT; c++) begin
        tick;
        n_checks++;
        if (gnt !== 4'(1 << order[n]) || avec !== ops[order[n]]) begin
          n_fail++;
          $display("[TB] FAIL rr_grant op%0d: gnt=%b avec=%h expected %b %h", n, gnt, avec, 4'(1 << order[n]), ops[order[n]]);
        end
      end
      tick;
      n_checks++;
      if (done !== 4'(1 << order[n]) || rdata !== ~ops[order[n]]) begin
        n_fail++;
        $display("[TB] FAIL rr_done op%0d: done=%b rdata=%h expected %b %h", n, done, rdata, 4'(1 << order[n]), ~ops[order[n]]);
      end
      if (n == 4) req = '0;
      tick;
      n_checks++;
      if (done !== 4'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL rr_idle op%0d: done=%b busy=%b expected 0000 0", n, done, busy);
      end
    end
    model_ptr = 0;
  endtask

  task automatic test_withdrawal;
    do_reset;
    req  = 4'b0010;
    opnd = 16'h00B0;
    tick;
    n_checks++;
    if (gnt !== 4'b0010) begin
      n_fail++;
      $display("[TB] FAIL wd_grant: gnt=%b expected 0010", gnt);
    end
    tick;
    req = 4'b0000;
    tick;
    n_checks++;
    if (done !== 4'b0010 || rdata !== 4'h4) begin
      n_fail++;
      $display("[TB] FAIL wd_done: done=%b rdata=%h expected 0010 4", done, rdata);
    end
    for (int c = 0; c < 4; c++) begin
      tick;
      n_checks++;
      if (gnt !== 4'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL wd_no_regrant c%0d: gnt=%b busy=%b expected 0000 0", c, gnt, busy);
      end
    end
    req = 4'b0001;
    tick;
    n_checks++;
    if (gnt !== 4'b0001) begin
      n_fail++;
      $display("[TB] FAIL wd_other_grant: gnt=%b expected 0001", gnt);
    end
    req = '0;
    for (int c = 0; c < LAT + 1; c++) tick;
    model_ptr = 0;
  endtask

  task automatic test_midop_reset;
    do_reset;
    req  = 4'b0100;
    opnd = 16'h7700;
    tick;
    n_checks++;
    if (gnt !== 4'b0100) begin
      n_fail++;
      $display("[TB] FAIL mr_grant: gnt=%b expected 0100", gnt);
    end
    rst = 1'b1;
    tick;
    n_checks++;
    if (gnt !== 4'b0 || avec !== 4'h0 || done !== 4'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL mr_abort: gnt=%b avec=%h done=%b busy=%b expected zeros", gnt, avec, done, busy);
    end
    rst  = 1'b0;
    req  = 4'b1000;
    opnd = 16'h6000;
    model_ptr = NREQ - 1;
    tick;
    n_checks++;
    if (gnt !== 4'(1 << rr_pick(model_ptr, 4'b1000)) || done !== 4'b0) begin
      n_fail++;
      $display("[TB] FAIL mr_regrant: gnt=%b done=%b expected 1000 0000", gnt, done);
    end
    for (int c = 2; c <= LAT; c++) begin
      tick;
      n_checks++;
      if (done !== 4'b0) begin
        n_fail++;
        $display("[TB] FAIL mr_no_done: done=%b expected 0000", done);
      end
    end
    tick;
    n_checks++;
    if (done !== 4'b1000 || rdata !== 4'h9) begin
      n_fail++;
      $display("[TB] FAIL mr_done: done=%b rdata=%h expected 1000 9", done, rdata);
    end
    req = '0;
    tick;
    model_ptr = 3;
  endtask

  task automatic test_operand_change;
    do_reset;
    req  = 4'b0001;
    opnd = 16'h0003;
    tick;
    n_checks++;
    if (avec !== 4'h3) begin
      n_fail++;
      $display("[TB] FAIL oc_avec1: avec=%h expected 3", avec);
    end
    opnd = 16'h000C;
    tick;
    n_checks++;
    if (avec !== 4'h3) begin
      n_fail++;
      $display("[TB] FAIL oc_avec2: avec=%h expected 3", avec);
    end
    tick;
    n_checks++;
    if (done !== 4'b0001 || rdata !== 4'hC) begin
      n_fail++;
      $display("[TB] FAIL oc_done: done=%b rdata=%h expected 0001 c", done, rdata);
    end
    req = '0;
    tick;
    model_ptr = 0;
  endtask

  task automatic test_random;
    logic [3:0] r;
    logic [3:0] opv;
    int w;
    for (int n = 0; n < 40; n++) begin
      r    = 4'($urandom_range(0, 15));
      opnd = 16'($urandom);
      req  = r;
      if (r == 4'b0) begin
        tick;
        n_checks++;
        if (gnt !== 4'b0 || busy !== 1'b0 || avec !== 4'h0) begin
          n_fail++;
          $display("[TB] FAIL rnd_idle n%0d: gnt=%b busy=%b avec=%h expected 0000 0 0", n, gnt, busy, avec);
        end
      end else begin
        w   = rr_pick(model_ptr, r);
        opv = opnd[w*W +: W];
        model_ptr = w;
        for (int c = 1; c <= LAT; c++) begin
          tick;
          n_checks++;
          if (gnt !== 4'(1 << w) || avec !== opv || busy !== 1'b1 || done !== 4'b0) begin
            n_fail++;
            $display("[TB] FAIL rnd_wait n%0d c%0d: gnt=%b avec=%h busy=%b done=%b expected %b %h 1 0000", n, c, gnt, avec, busy, done, 4'(1 << w), opv);
          end
          opnd = 16'($urandom);
          if ($urandom_range(0, 3) == 0) req = 4'b0;
        end
        tick;
        n_checks++;
        if (done !== 4'(1 << w) || rdata !== ~opv || gnt !== 4'b0) begin
          n_fail++;
          $display("[TB] FAIL rnd_done n%0d: done=%b rdata=%h gnt=%b expected %b %h 0000", n, done, rdata, gnt, 4'(1 << w), ~opv);
        end
        req = 4'b0;
        tick;
        n_checks++;
        if (busy !== 1'b0 || done !== 4'b0) begin
          n_fail++;
          $display("[TB] FAIL rnd_end n%0d: busy=%b done=%b expected 0 0000", n, busy, done);
        end
      end
    end
  endtask

  initial begin
    rst  = 1'b1;
    req  = '0;
    opnd = '0;
    model_ptr = NREQ - 1;
    tick;
    tick;
    test_reset;
    test_single;
    test_round_robin;
    test_withdrawal;
    test_midop_reset;
    test_operand_change;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
